// File: rtl/simd_cu.sv
// Operand store: three independent DEPTHxDATA_W banks, one write port and two registered read ports each.
// Optional macro READ_BYPASS_EN forwards same-cycle write data to a read of the same bank/address.
module simd_cu #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d,
    input  logic [DATA_W-1:0] d1,
    input  logic [DATA_W-1:0] d2,
    input  logic              en_write,
    input  logic              en_read,
    input  logic [ADDR_W-1:0] reg_write_addr1,
    input  logic [ADDR_W-1:0] reg_write_addr2,
    input  logic [ADDR_W-1:0] reg_write_addr3,
    input  logic [ADDR_W-1:0] reg_read_addr1,
    input  logic [ADDR_W-1:0] reg_read_addr2,
    input  logic [ADDR_W-1:0] reg_read_addr3,
    input  logic [ADDR_W-1:0] reg_read_addr4,
    input  logic [ADDR_W-1:0] reg_read_addr5,
    input  logic [ADDR_W-1:0] reg_read_addr6,
    output logic [DATA_W-1:0] reg_read_data1,
    output logic [DATA_W-1:0] reg_read_data2,
    output logic [DATA_W-1:0] reg_read_data3,
    output logic [DATA_W-1:0] reg_read_data4,
    output logic [DATA_W-1:0] reg_read_data5,
    output logic [DATA_W-1:0] reg_read_data6
);

    localparam int BANKS = 3;
    localparam int PORTS = 2;

    logic [BANKS-1:0][DATA_W-1:0]       wr_data;
    logic [BANKS-1:0][ADDR_W-1:0]       wr_addr;
    logic [BANKS*PORTS-1:0][ADDR_W-1:0] rd_addr;
    logic [BANKS*PORTS-1:0][DATA_W-1:0] rd_data;

    assign wr_data[0] = d;
    assign wr_data[1] = d1;
    assign wr_data[2] = d2;

    assign wr_addr[0] = reg_write_addr1;
    assign wr_addr[1] = reg_write_addr2;
    assign wr_addr[2] = reg_write_addr3;

    assign rd_addr[0] = reg_read_addr1;
    assign rd_addr[1] = reg_read_addr2;
    assign rd_addr[2] = reg_read_addr3;
    assign rd_addr[3] = reg_read_addr4;
    assign rd_addr[4] = reg_read_addr5;
    assign rd_addr[5] = reg_read_addr6;

    genvar gi, gp;
    generate
        for (gi = 0; gi < BANKS; gi++) begin : g_bank
            // Register-based storage: the whole bank must clear on asynchronous reset.
            logic [DATA_W-1:0] mem_reg [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_reg[i] <= '0;
                    end
                end else if (en_write) begin
                    mem_reg[wr_addr[gi]] <= wr_data[gi];
                end
            end

            for (gp = 0; gp < PORTS; gp++) begin : g_port
                logic [DATA_W-1:0] rd_reg;
                logic [DATA_W-1:0] rd_next;

                always_comb begin
                    rd_next = mem_reg[rd_addr[gi*PORTS+gp]];
`ifdef READ_BYPASS_EN
                    if (en_write && (wr_addr[gi] == rd_addr[gi*PORTS+gp])) begin
                        rd_next = wr_data[gi];
                    end
`endif
                end

                // Outputs hold when reads are disabled; only reset zeroes them.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        rd_reg <= '0;
                    end else if (en_read) begin
                        rd_reg <= rd_next;
                    end
                end

                assign rd_data[gi*PORTS+gp] = rd_reg;
            end
        end
    endgenerate

    assign reg_read_data1 = rd_data[0];
    assign reg_read_data2 = rd_data[1];
    assign reg_read_data3 = rd_data[2];
    assign reg_read_data4 = rd_data[3];
    assign reg_read_data5 = rd_data[4];
    assign reg_read_data6 = rd_data[5];

endmodule

// File: tb/tb_simd_cu.sv
// Bench for simd_cu: directed steps plus random traffic checked against an array-based reference model.
`timescale 1ns/1ps
module tb_simd_cu;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wd [3];
    logic [3:0] wa [3];
    logic [3:0] ra [6];
    logic       en_write, en_read;
    logic [7:0] q1, q2, q3, q4, q5, q6;
    logic [7:0] obs [6];

    logic [7:0] ref_mem [3][16];
    logic [7:0] ref_out [6];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    simd_cu dut (
        .clk(clk), .rst_n(rst_n),
        .d(wd[0]), .d1(wd[1]), .d2(wd[2]),
        .en_write(en_write), .en_read(en_read),
        .reg_write_addr1(wa[0]), .reg_write_addr2(wa[1]), .reg_write_addr3(wa[2]),
        .reg_read_addr1(ra[0]), .reg_read_addr2(ra[1]), .reg_read_addr3(ra[2]),
        .reg_read_addr4(ra[3]), .reg_read_addr5(ra[4]), .reg_read_addr6(ra[5]),
        .reg_read_data1(q1), .reg_read_data2(q2), .reg_read_data3(q3),
        .reg_read_data4(q4), .reg_read_data5(q5), .reg_read_data6(q6)
    );

    always_comb begin
        obs[0] = q1; obs[1] = q2; obs[2] = q3;
        obs[3] = q4; obs[4] = q5; obs[5] = q6;
    end

    task automatic check(input string tag, input int port, input logic [7:0] expv);
        tests++;
        assert (obs[port] === expv) else begin
            fails++;
            $error("FAIL %s port%0d observed=%h expected=%h", tag, port + 1, obs[port], expv);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++)
            for (int a = 0; a < 16; a++) ref_mem[b][a] = 8'h00;
        for (int p = 0; p < 6; p++) ref_out[p] = 8'h00;
    endtask

    // One clock: model applies read (old contents, or forwarded data) then write.
    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (en_read) begin
            for (int p = 0; p < 6; p++) begin
                ref_out[p] = ref_mem[p / 2][ra[p]];
`ifdef READ_BYPASS_EN
                if (en_write && wa[p / 2] == ra[p]) ref_out[p] = wd[p / 2];
`endif
            end
        end
        if (en_write)
            for (int b = 0; b < 3; b++) ref_mem[b][wa[b]] = wd[b];
        for (int p = 0; p < 6; p++) check(tag, p, ref_out[p]);
        $display("[TB] %s we=%0b re=%0b out=%h %h %h %h %h %h", tag, en_write, en_read,
                 q1, q2, q3, q4, q5, q6);
    endtask

    task automatic set_write(input logic [3:0] a, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
        for (int b = 0; b < 3; b++) wa[b] = a;
        wd[0] = b0; wd[1] = b1; wd[2] = b2;
    endtask

    task automatic set_read_all(input logic [3:0] a);
        for (int p = 0; p < 6; p++) ra[p] = a;
    endtask

    task automatic check_row(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2);
        check(tag, 0, b0); check(tag, 1, b0);
        check(tag, 2, b1); check(tag, 3, b1);
        check(tag, 4, b2); check(tag, 5, b2);
    endtask

    initial begin
        logic [7:0] coll;
        rst_n = 1'b0; en_write = 1'b0; en_read = 1'b0;
        set_write(4'd0, 8'h00, 8'h00, 8'h00);
        set_read_all(4'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_row("reset_initial", 8'h00, 8'h00, 8'h00);
        rst_n = 1'b1;

        // Row write then read.
        en_write = 1'b1; set_write(4'd0, 8'h01, 8'h02, 8'h03);
        tick("row_write");
        en_write = 1'b0; en_read = 1'b1; set_read_all(4'd0);
        tick("row_read");
        check_row("row_read_const", 8'h01, 8'h02, 8'h03);

        // Fill rows 0..8; rows 3 and 5 replicate row 2, rows 6..8 zero.
        en_read = 1'b0; en_write = 1'b1;
        for (int r = 0; r < 9; r++) begin
            case (r)
                2, 3, 5: set_write(r[3:0], 8'h4C, 8'hB9, 8'hD6);
                4:       set_write(r[3:0], 8'h48, 8'hA9, 8'hD0);
                6, 7, 8: set_write(r[3:0], 8'h00, 8'h00, 8'h00);
                default: set_write(r[3:0], 8'h10 + r[7:0], 8'h20 + r[7:0], 8'h30 + r[7:0]);
            endcase
            tick("fill");
        end
        en_write = 1'b0; en_read = 1'b1;
        set_read_all(4'd2); tick("fill_rd2"); check_row("fill_rd2_const", 8'h4C, 8'hB9, 8'hD6);
        set_read_all(4'd3); tick("fill_rd3"); check_row("fill_rd3_const", 8'h4C, 8'hB9, 8'hD6);
        set_read_all(4'd5); tick("fill_rd5"); check_row("fill_rd5_const", 8'h4C, 8'hB9, 8'hD6);

        // Hold with en_read low while addresses move.
        set_read_all(4'd4); tick("hold_rd4");
        en_read = 1'b0; set_read_all(4'd9);
        tick("hold_1"); check_row("hold_1_const", 8'h48, 8'hA9, 8'hD0);
        set_read_all(4'd15);
        tick("hold_2"); check_row("hold_2_const", 8'h48, 8'hA9, 8'hD0);

        // Split ports of one bank.
        en_read = 1'b1; ra[0] = 4'd2; ra[1] = 4'd4;
        tick("split");
        check("split_a", 0, 8'h4C); check("split_b", 1, 8'h48);

        // Write/read collision at addr 7 (old contents 00).
        en_write = 1'b1; set_write(4'd7, 8'h5A, 8'h6B, 8'h7C); set_read_all(4'd7);
        tick("collision");
`ifdef READ_BYPASS_EN
        coll = 8'h5A;
`else
        coll = 8'h00;
`endif
        check("collision_const", 0, coll);
        en_write = 1'b0;
        tick("after_collision");
        check_row("after_collision_const", 8'h5A, 8'h6B, 8'h7C);

        // Random traffic with an asynchronous reset in the middle.
        for (int n = 0; n < 300; n++) begin
            en_write = 1'($urandom_range(0, 1));
            en_read  = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < 3; b++) begin
                wa[b] = 4'($urandom_range(0, 15));
                wd[b] = 8'($urandom);
            end
            for (int p = 0; p < 6; p++)
                ra[p] = ($urandom_range(0, 3) == 0) ? wa[p / 2] : 4'($urandom_range(0, 15));
            if (n == 150) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                check_row("async_reset", 8'h00, 8'h00, 8'h00);
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick("random");
        end

        // Sweep every address after a final reset: all entries must read zero.
        #2 rst_n = 1'b0;
        #1 model_reset();
        @(negedge clk);
        rst_n = 1'b1; en_write = 1'b0; en_read = 1'b1;
        for (int a = 0; a < 16; a++) begin
            set_read_all(a[3:0]);
            tick("reset_sweep");
            check_row("reset_sweep_const", 8'h00, 8'h00, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
